iact_vector_dispatcher: RTL and testbench
=========================================

// Module: iact_vector_dispatcher
// PURPOSE
//  Producer side of the PE-vector iact FIFO interface. Reads activations from a narrow on-chip SRAM.
//  Packs MEM_LANES-channel words into one NUM_OF_CHANNEL-wide channel vector.
//  Pushes each vector into the PE FIFOs with one fifo_en/fifo_wea pulse.
//  Sits between the activation buffer and the PE vector; one instance per PE vector.
// PARAMETERS
//  DATA_BITWIDTH      8   bits per activation
//  NUM_OF_CHANNEL     32  channels per vector; must be a multiple of MEM_LANES
//  MEM_LANES          8   activations per SRAM word; BEATS = NUM_OF_CHANNEL/MEM_LANES (localparam)
//  MEM_ADDR_BITWIDTH  10  SRAM word address width
//  VEC_CNT_BITWIDTH   8   width of vector-count request
// PORTS
//  clk         in   1                           single clock, rising edge
//  rstN        in   1                           asynchronous, active-low reset
//  start       in   1                           1-cycle request; sampled only in IDLE
//  base_addr   in   MEM_ADDR_BITWIDTH           first SRAM word address, latched on start
//  num_vectors in   VEC_CNT_BITWIDTH            vectors to dispatch, latched on start
//  pe_ready    in   1                           PE FIFOs can accept a vector this cycle
//  mem_en      out  1                           SRAM read enable
//  mem_addr    out  MEM_ADDR_BITWIDTH           SRAM read address
//  mem_rdata   in   MEM_LANES*DATA_BITWIDTH     SRAM data, valid 1 cycle after mem_en
//  fifo_en     out  1                           PE FIFO enable
//  fifo_wea    out  1                           PE FIFO write strobe; always equal to fifo_en
//  iact        out  NUM_OF_CHANNEL*DATA_BITWIDTH  channel vector; channel c at [c*DW +: DW]
//  busy        out  1                           high from the cycle after accepted start until done
//  done        out  1                           1-cycle pulse after the last push
// BEHAVIOUR
//  Reset: every output is 0, including iact and mem_addr. The FSM is in IDLE and the counters are cleared.
//  Reset is honoured mid-operation: the job is discarded, and no further mem_en or fifo_en occurs until a new start.
//  FSM states:
//   IDLE:
//    - start=1 and num_vectors=0: go to DONE.
//    - start=1 and num_vectors>0: go to FETCH.
//    - start is ignored in every state other than IDLE.
//   FETCH:
//    - mem_en=1 for BEATS consecutive cycles.
//    - mem_addr = current address; it increments each beat and wraps modulo 2^MEM_ADDR_BITWIDTH.
//    - The address continues across vectors; it is never reset to base_addr within a job.
//    - After beat BEATS-1, go to LAST.
//   LAST:
//    - One cycle with mem_en=0. It captures the final beat's data.
//    - Go to PUSH.
//   PUSH:
//    - Wait in PUSH while pe_ready=0. mem_en=0 in this state, so there is no SRAM traffic.
//    - When pe_ready=1: fifo_en=fifo_wea=1 for exactly that cycle, and the remaining-vector count decrements.
//    - Then go to FETCH if vectors remain; otherwise go to DONE.
//   DONE:
//    - done=1 for one cycle, busy=0.
//    - Go to IDLE.
//  Packing:
//   - Data of beat k (arriving the cycle after its mem_en) writes channels k*MEM_LANES .. k*MEM_LANES+MEM_LANES-1.
//   - Lane l of mem_rdata maps to channel k*MEM_LANES+l.
//   - iact is registered. It is stable and complete during the fifo_en cycle.
//   - iact holds its last value between pushes; partial updates during FETCH are allowed.
//  Timing:
//   - Minimum per-vector cost is BEATS+2 cycles.
//   - With pe_ready=1, the first fifo_en occurs BEATS+2 cycles after the cycle in which start was sampled (6 with defaults).
//   - done occurs the cycle after the last fifo_en.
//  Widths: the count is zero-extended, with no arithmetic on data. There are no overflow cases beyond address wrap.
// STRUCTURE
//  Shared header (iact_dispatch_defs.vh):
//   - FSM state encodings IDLE/FETCH/LAST/PUSH/DONE.
//   - BEATS and beat-counter width macro, clog2(BEATS) with a minimum of 1.
//  Sub-module iact_vector_packer:
//   - Beat-indexed lane register.
//   - Inputs: clk, rstN, wr_en, beat_idx, mem_rdata. Output: iact.
//   - Reset clears it to 0.
//  The top level holds the FSM, address counter, beat counter and vector counter.
// TESTING
//  1 Reset: hold rstN=0 with random inputs -> all outputs 0; after release with no start -> no mem_en.
//  2 Single vector (base=0, n=1):
//    - SRAM word k, lane l = k*8+l.
//    - Expect mem_addr 0,1,2,3, then fifo_en=fifo_wea=1 at cycle 6 after start.
//    - At that cycle, iact channel c == c for c = 0..31; done on the next cycle.
//  3 Backpressure: n=3, pe_ready=0 for 5 cycles at the 2nd PUSH.
//    - No mem_en while stalled; exactly 3 fifo_en pulses.
//    - Addresses run 0..11 contiguously; a single done pulse.
//  4 Zero length and busy-start: n=0 -> done the cycle after start, with no mem_en or fifo_en.
//    - A start pulse during a busy n=2 job is ignored: exactly 2 pushes.
//  5 Address wrap: base=1022, n=1 -> mem_addr 1022,1023,0,1; the pushed vector matches those words in order.
//  6 Mid-job reset: assert rstN=0 during the 2nd FETCH beat -> all outputs 0 asynchronously.
//    - After release and a new start (n=1, base=8), a correct vector from words 8..11 is pushed.

Source files
------------

// File: rtl/iact_vector_dispatcher_pkg.sv
// Shared types and defaults for the PE-vector iact dispatcher.
package iact_vector_dispatcher_pkg;

  localparam int unsigned DATA_BITWIDTH_DEF     = 8;
  localparam int unsigned NUM_OF_CHANNEL_DEF    = 32;
  localparam int unsigned MEM_LANES_DEF         = 8;
  localparam int unsigned MEM_ADDR_BITWIDTH_DEF = 10;
  localparam int unsigned VEC_CNT_BITWIDTH_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LAST  = 3'd2,
    ST_PUSH  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Beat counter width: clog2(beats), never narrower than one bit.
  function automatic int unsigned beat_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/iact_vector_dispatcher_packer.sv
// Beat-indexed lane register that assembles SRAM words into one channel vector.
module iact_vector_packer
  import iact_vector_dispatcher_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH  = DATA_BITWIDTH_DEF,
  parameter int unsigned NUM_OF_CHANNEL = NUM_OF_CHANNEL_DEF,
  parameter int unsigned MEM_LANES      = MEM_LANES_DEF,
  parameter int unsigned BEATS          = NUM_OF_CHANNEL / MEM_LANES,
  parameter int unsigned BEAT_W         = beat_width(BEATS)
) (
  input  logic                                     clk,
  input  logic                                     rstN,
  input  logic                                     wr_en,
  input  logic [BEAT_W-1:0]                        beat_idx,
  input  logic [MEM_LANES*DATA_BITWIDTH-1:0]       mem_rdata,
  output logic [NUM_OF_CHANNEL*DATA_BITWIDTH-1:0]  iact
);

  localparam int unsigned LW = MEM_LANES * DATA_BITWIDTH;
  localparam int unsigned VW = NUM_OF_CHANNEL * DATA_BITWIDTH;

  logic [VW-1:0] iact_q;
  logic [VW-1:0] iact_d;

  // Only the slice owned by the current beat changes; the rest holds.
  always_comb begin
    iact_d = iact_q;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (wr_en && (beat_idx == BEAT_W'(b))) begin
        iact_d[b*LW +: LW] = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      iact_q <= '0;
    end else begin
      iact_q <= iact_d;
    end
  end

  assign iact = iact_q;

endmodule

// File: rtl/iact_vector_dispatcher.sv
// Producer side of the PE iact FIFO interface: fetches BEATS SRAM words per
// vector, packs them, and pushes one vector per fifo_en pulse.
module iact_vector_dispatcher
  import iact_vector_dispatcher_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH     = DATA_BITWIDTH_DEF,
  parameter int unsigned NUM_OF_CHANNEL    = NUM_OF_CHANNEL_DEF,
  parameter int unsigned MEM_LANES         = MEM_LANES_DEF,
  parameter int unsigned MEM_ADDR_BITWIDTH = MEM_ADDR_BITWIDTH_DEF,
  parameter int unsigned VEC_CNT_BITWIDTH  = VEC_CNT_BITWIDTH_DEF
) (
  input  logic                                     clk,
  input  logic                                     rstN,
  input  logic                                     start,
  input  logic [MEM_ADDR_BITWIDTH-1:0]             base_addr,
  input  logic [VEC_CNT_BITWIDTH-1:0]              num_vectors,
  input  logic                                     pe_ready,
  output logic                                     mem_en,
  output logic [MEM_ADDR_BITWIDTH-1:0]             mem_addr,
  input  logic [MEM_LANES*DATA_BITWIDTH-1:0]       mem_rdata,
  output logic                                     fifo_en,
  output logic                                     fifo_wea,
  output logic [NUM_OF_CHANNEL*DATA_BITWIDTH-1:0]  iact,
  output logic                                     busy,
  output logic                                     done
);

  localparam int unsigned BEATS  = NUM_OF_CHANNEL / MEM_LANES;
  localparam int unsigned BEAT_W = beat_width(BEATS);
  localparam int unsigned AW     = MEM_ADDR_BITWIDTH;
  localparam int unsigned CW     = VEC_CNT_BITWIDTH;

  state_e              state_q,   state_d;
  logic                mem_en_q,  mem_en_d;
  logic [AW-1:0]       addr_q,    addr_d;
  logic [BEAT_W-1:0]   beat_q,    beat_d;
  logic [CW-1:0]       vec_cnt_q, vec_cnt_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;
  logic                rd_vld_q,  rd_vld_d;
  logic [BEAT_W-1:0]   rd_beat_q, rd_beat_d;

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    mem_en_d  = 1'b0;
    addr_d    = addr_q;
    beat_d    = beat_q;
    vec_cnt_d = vec_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_vld_d  = mem_en_q;
    rd_beat_d = beat_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_vectors == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_FETCH;
            mem_en_d  = 1'b1;
            addr_d    = base_addr;
            beat_d    = '0;
            vec_cnt_d = num_vectors;
            busy_d    = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        // Address keeps counting into the next vector; wraps naturally.
        addr_d = addr_q + AW'(1);
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          beat_d  = '0;
          state_d = ST_LAST;
        end else begin
          beat_d   = beat_q + BEAT_W'(1);
          mem_en_d = 1'b1;
        end
      end
      ST_LAST: begin
        state_d = ST_PUSH;
      end
      ST_PUSH: begin
        if (pe_ready) begin
          vec_cnt_d = vec_cnt_q - CW'(1);
          if (vec_cnt_q == CW'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d  = ST_FETCH;
            mem_en_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= ST_IDLE;
      mem_en_q  <= 1'b0;
      addr_q    <= '0;
      beat_q    <= '0;
      vec_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_beat_q <= '0;
    end else begin
      state_q   <= state_d;
      mem_en_q  <= mem_en_d;
      addr_q    <= addr_d;
      beat_q    <= beat_d;
      vec_cnt_q <= vec_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_vld_q  <= rd_vld_d;
      rd_beat_q <= rd_beat_d;
    end
  end

  // SRAM data lands one cycle after mem_en; rd_* carries that beat's index.
  iact_vector_packer #(
    .DATA_BITWIDTH  (DATA_BITWIDTH),
    .NUM_OF_CHANNEL (NUM_OF_CHANNEL),
    .MEM_LANES      (MEM_LANES),
    .BEATS          (BEATS),
    .BEAT_W         (BEAT_W)
  ) u_packer (
    .clk       (clk),
    .rstN      (rstN),
    .wr_en     (rd_vld_q),
    .beat_idx  (rd_beat_q),
    .mem_rdata (mem_rdata),
    .iact      (iact)
  );

  // The push must land in the same cycle pe_ready is seen.
  assign fifo_en  = (state_q == ST_PUSH) && pe_ready;
  assign fifo_wea = fifo_en;
  assign mem_en   = mem_en_q;
  assign mem_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_iact_vector_dispatcher.sv
// Scoreboard bench for iact_vector_dispatcher: expected addresses and vectors
// are queued at start and consumed as the DUT reads SRAM and pushes.
module tb_iact_vector_dispatcher;

  localparam int DW    = 8;
  localparam int NCH   = 32;
  localparam int LANES = 8;
  localparam int AW    = 10;
  localparam int VCW   = 8;
  localparam int BEATS = NCH / LANES;
  localparam int DEPTH = 1 << AW;

  logic                  clk = 1'b0;
  logic                  rstN = 1'b0;
  logic                  start = 1'b0;
  logic [AW-1:0]         base_addr = '0;
  logic [VCW-1:0]        num_vectors = '0;
  logic                  pe_ready = 1'b0;
  logic                  mem_en;
  logic [AW-1:0]         mem_addr;
  logic [LANES*DW-1:0]   mem_rdata = '0;
  logic                  fifo_en;
  logic                  fifo_wea;
  logic [NCH*DW-1:0]     iact;
  logic                  busy;
  logic                  done;

  iact_vector_dispatcher dut (
    .clk         (clk),
    .rstN        (rstN),
    .start       (start),
    .base_addr   (base_addr),
    .num_vectors (num_vectors),
    .pe_ready    (pe_ready),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .fifo_en     (fifo_en),
    .fifo_wea    (fifo_wea),
    .iact        (iact),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency.
  logic [LANES*DW-1:0] mem [DEPTH];
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int s_cyc, last_push, prev_push, push_cnt, done_cnt, done_cyc, beats_seen;
  logic [AW-1:0]     exp_addr_q[$];
  logic [NCH*DW-1:0] exp_vec_q[$];

  function automatic logic [7:0] lane_val(input int w, input int l);
    return 8'(w * 8 + l);
  endfunction

  task automatic check(input string tag, input logic [299:0] got, input logic [299:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int base, input int n);
    logic [AW-1:0]     a;
    logic [NCH*DW-1:0] v;
    for (int vi = 0; vi < n; vi++) begin
      v = '0;
      for (int k = 0; k < BEATS; k++) begin
        a = AW'(base + vi * BEATS + k);
        exp_addr_q.push_back(a);
        for (int l = 0; l < LANES; l++) v[(k*LANES+l)*DW +: DW] = lane_val(int'(a), l);
      end
      exp_vec_q.push_back(v);
    end
  endtask

  task automatic start_job(input int base, input int n);
    @(posedge clk); #1;
    base_addr   = AW'(base);
    num_vectors = VCW'(n);
    start       = 1'b1;
    s_cyc       = cyc;
    push_exp(base, n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    int d0;
    int t;
    d0 = done_cnt;
    t  = 0;
    while (done_cnt == d0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (done_cnt == d0) check("done_timeout", 0, 1);
    dc = done_cyc;
  endtask

  initial begin
    int dc, p0, d0, p1cyc, t;
    last_push = 0; prev_push = 0; push_cnt = 0; done_cnt = 0; done_cyc = 0; beats_seen = 0; s_cyc = 0;
    for (int w = 0; w < DEPTH; w++)
      for (int l = 0; l < LANES; l++) mem[w][l*DW +: DW] = lane_val(w, l);

    fork
      forever begin
        @(negedge clk);
        if (rstN) begin
          if (mem_en) begin
            if (beats_seen == BEATS) check("mem_en_before_push", 1, 0);
            else beats_seen++;
            if (exp_addr_q.size() == 0) check("mem_en_unexpected", 1, 0);
            else check("mem_addr", mem_addr, exp_addr_q.pop_front());
          end
          if (fifo_en || fifo_wea) begin
            check("fifo_wea", fifo_wea, fifo_en);
            check("push_ready", pe_ready, 1);
            check("beats_before_push", beats_seen, BEATS);
            beats_seen = 0;
            if (exp_vec_q.size() == 0) check("push_unexpected", 1, 0);
            else check("iact", iact, exp_vec_q.pop_front());
            prev_push = last_push;
            last_push = cyc;
            push_cnt++;
          end
          if (done) begin
            done_cnt++;
            done_cyc = cyc;
          end
        end
      end
    join_none

    // 1: reset with random inputs
    repeat (6) begin
      @(posedge clk); #1;
      start       = 1'($urandom);
      base_addr   = AW'($urandom);
      num_vectors = VCW'($urandom);
      pe_ready    = 1'($urandom);
      #3 check("reset_outputs", {mem_en, mem_addr, fifo_en, fifo_wea, busy, done, iact}, '0);
    end
    start = 1'b0;
    pe_ready = 1'b1;
    @(posedge clk); #1 rstN = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("idle_quiet", {mem_en, busy, fifo_en, done}, '0);

    // 2: single vector, latency and packing
    start_job(0, 1);
    check("busy_after_start", busy, 1);
    wait_done(dc);
    check("first_push_latency", last_push - s_cyc, BEATS + 2);
    check("done_after_push", dc - last_push, 1);
    check("busy_after_done", busy, 0);

    // 3: backpressure at the second PUSH
    p0 = push_cnt;
    d0 = done_cnt;
    start_job(0, 3);
    t = 0;
    while (push_cnt < p0 + 1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("bp_first_push_seen", push_cnt - p0, 1);
    p1cyc = last_push;
    pe_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1 pe_ready = 1'b1;
    wait_done(dc);
    check("bp_push_count", push_cnt - p0, 3);
    check("bp_stalled_push_cycle", prev_push - p1cyc, BEATS + 2 + 5);
    repeat (3) @(posedge clk);
    #1 check("bp_single_done", done_cnt - d0, 1);
    check("bp_addr_drained", exp_addr_q.size(), 0);

    // 4: zero length, then start while busy
    p0 = push_cnt;
    start_job(5, 0);
    wait_done(dc);
    check("zero_len_done_cycle", dc - s_cyc, 1);
    check("zero_len_no_push", push_cnt - p0, 0);
    start_job(200, 2);
    repeat (3) @(posedge clk);
    #1;
    base_addr   = AW'(100);
    num_vectors = VCW'(5);
    start       = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(dc);
    check("busy_start_pushes", push_cnt - p0, 2);
    repeat (4) @(posedge clk);
    #1 check("busy_start_no_new_job", {busy, mem_en}, '0);

    // 5: address wrap
    start_job(1022, 1);
    wait_done(dc);
    check("wrap_vec_drained", exp_vec_q.size(), 0);

    // 6: reset during the second fetch beat
    start_job(0, 2);
    @(posedge clk); #1 rstN = 1'b0;
    #1 check("async_reset_outputs", {mem_en, mem_addr, fifo_en, fifo_wea, busy, done, iact}, '0);
    exp_addr_q.delete();
    exp_vec_q.delete();
    beats_seen = 0;
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("post_reset_quiet", {mem_en, busy, fifo_en}, '0);
    p0 = push_cnt;
    start_job(8, 1);
    wait_done(dc);
    check("post_reset_push", push_cnt - p0, 1);
    check("post_reset_drained", exp_vec_q.size() + exp_addr_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
